// File: rtl/seq_det_arbiter.sv
// Two-requester round-robin front end feeding a serial "1011" overlap detector.
// Optional SEQ_DET_ARBITER_TOTAL_EN adds a saturating running total of hits.
module seq_det_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [1:0] rsp_count,
`ifdef SEQ_DET_ARBITER_TOTAL_EN
  output logic [7:0] total_hits,
`endif
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StShift, StDrain, StDone} state_e;
  typedef enum logic [2:0] {DetS0, DetS1, DetS2, DetS3, DetS4} det_e;

  state_e     state_q, state_d;
  det_e       det_q, det_d, det_next;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [1:0] hit_cnt_q, hit_cnt_d;
  logic       id_q, id_d;
  logic       last_grant_q, last_grant_d;
  logic       grant0, grant1, hit, x;

  assign x   = shift_q[7];
  assign hit = (det_q == DetS4);

  // Round robin: on contention the requester that did not win last time goes.
  assign grant0 = req0_valid && (!req1_valid || last_grant_q);
  assign grant1 = req1_valid && (!req0_valid || !last_grant_q);

  always_comb begin
    det_next = DetS0;
    unique case (det_q)
      DetS0:   det_next = x ? DetS1 : DetS0;
      DetS1:   det_next = x ? DetS1 : DetS2;
      DetS2:   det_next = x ? DetS3 : DetS0;
      DetS3:   det_next = x ? DetS4 : DetS2;
      DetS4:   det_next = x ? DetS1 : DetS2;
      default: det_next = DetS0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    det_d        = det_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    hit_cnt_d    = hit_cnt_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Readys are masked while reset is asserted so no handshake is seen.
        req0_ready = rst && grant0;
        req1_ready = rst && grant1;
        if (grant0 || grant1) begin
          shift_d      = grant1 ? req1_data : req0_data;
          det_d        = DetS0;
          bit_cnt_d    = 3'd0;
          hit_cnt_d    = 2'd0;
          id_d         = grant1;
          last_grant_d = grant1;
          state_d      = StShift;
        end
      end
      StShift: begin
        hit_cnt_d = hit_cnt_q + {1'b0, hit};
        det_d     = det_next;
        shift_d   = {shift_q[6:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = StDrain;
      end
      StDrain: begin
        // Picks up a match completed by the final bit.
        hit_cnt_d = hit_cnt_q + {1'b0, hit};
        state_d   = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign rsp_valid = rst && (state_q == StDone);
  assign rsp_id    = rsp_valid && id_q;
  assign rsp_count = rsp_valid ? hit_cnt_q : 2'd0;
  assign busy      = rst && (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      det_q        <= DetS0;
      shift_q      <= 8'd0;
      bit_cnt_q    <= 3'd0;
      hit_cnt_q    <= 2'd0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      det_q        <= det_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      hit_cnt_q    <= hit_cnt_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef SEQ_DET_ARBITER_TOTAL_EN
  logic [7:0] total_q, total_d;
  logic [8:0] total_sum;

  assign total_sum = {1'b0, total_q} + {7'd0, hit_cnt_q};

  always_comb begin
    total_d = total_q;
    if (state_q == StDone) total_d = total_sum[8] ? 8'hFF : total_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) total_q <= 8'd0;
    else      total_q <= total_d;
  end

  assign total_hits = total_q;
`endif

endmodule
